bus_arbiter_rr: RTL
===================

# bus_arbiter_rr

Round-robin arbiter that shares one 4:1 tri-state bus among four requesters. It drives the select and output-enable inputs of the shared multiplexer, and grants the bus to one requester at a time. Every change of owner passes through a turnaround cycle in which the bus is undriven (oe low), so two drivers never overlap. It sits between the requesting units and the multiplexer stage.

## Interface
- MAX_HOLD, 8: maximum consecutive bus-owned cycles per grant; 0 disables the limit.
- HOLD_W, 4: width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  req[i] high means requester i wants the bus; it must stay high until granted.
- done  input  4  done[i] is a one-cycle pulse from owner i releasing the bus; ignored from non-owners.
- gnt  output  4  one-hot grant; all zero when there is no owner.
- S  output  2  select to the multiplexer; index of the current or last owner.
- oe  output  1  enable to the multiplexer's tri-state driver.
- busy  output  1  high in any state other than IDLE.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

## Operation
- All outputs are registered and are decoded from the state and the owner register.
- Internal registers:
  - state: IDLE / SETUP / OWN / TURN.
  - owner[1:0]: current owner.
  - last[1:0]: previous owner.
  - hold[HOLD_W-1:0]: hold counter.
- Reset values: state=IDLE, owner=0, last=3, hold=0, gnt=0000, S=00, oe=0, busy=0, timeout=0.
- With last=3 after reset, requester 0 has first priority.
- Arbitration (IDLE only): the winner is the first i with req[i]=1, searching cyclically from last+1 (last+1, last+2, last+3, last).
- IDLE:
  - No req: stay in IDLE.
  - Otherwise: owner <= winner, S <= winner, gnt <= onehot(winner), go to SETUP.
- SETUP: oe=0, and gnt and S are valid. Go unconditionally to OWN with hold <= 0.
- OWN: oe=1, gnt and S are held, and hold increments each cycle.
- Exit OWN to TURN on any of these:
  - done[owner]=1;
  - req[owner]=0;
  - MAX_HOLD≠0 and hold==MAX_HOLD-1. In this case timeout=1 during the first TURN cycle, but only if neither done[owner] nor a req[owner] drop caused the exit in the same cycle.
- TURN: oe=0, gnt=0000, S holds the old owner, last <= owner. Go unconditionally to IDLE.
- The hold counter wraps through the HOLD_W arithmetic only if MAX_HOLD=0; the wrap has no effect.
- done bits from non-owners are ignored in every state. req changes during SETUP are ignored.
- If req[owner] is still high after a timeout, that requester re-competes in IDLE. It has the lowest priority, because last now equals it.
- rst asserted in any state forces the reset values on the next edge, including mid-OWN. oe therefore drops one cycle after rst is sampled high.

## Timing
- Grant latency from IDLE: req sampled high at edge n gives gnt and S valid after edge n, and oe=1 after edge n+1.
- Release: done sampled at edge m gives oe=0 and gnt=0 after edge m (TURN), and IDLE after edge m+1.
- A new grant (SETUP) therefore appears after edge m+2 at the earliest. The bus is undriven for at least 3 cycles between owners (TURN, IDLE, SETUP).
- Maximum oe-high run per grant is MAX_HOLD cycles.
- Full cycle for a back-to-back owner change: OWN → TURN → IDLE → SETUP → OWN.
- Invariants on every cycle:
  - oe=1 implies exactly one gnt bit is set and S equals its index;
  - gnt never has more than one bit set;
  - S never changes while oe=1.

## Test plan
- Reset then single request: rst=1 for 2 cycles, then req=0100. Required: gnt=0100 and S=10 one cycle later, oe=1 the cycle after that. done=0100 pulse gives oe=0 and gnt=0000 on the next cycle.
- Round-robin fairness: req=1111 held, each owner pulses done after 2 OWN cycles. Required grant order 0,1,2,3,0, with S=00,01,10,11,00.
- Hold limit: MAX_HOLD=3, req=0010 held, no done. Required: exactly 3 oe-high cycles, a single timeout pulse in TURN, and requester 1 regranted after IDLE.
- Priority rotation under timeout: MAX_HOLD=3, req=0011 held. Required: grants alternate 0,1,0,1 and timeout pulses once per grant.
- Early drop and spurious done: owner 2 in OWN, done=1001 (non-owners). Required: no effect. Then req[2] drops, giving TURN on the next edge with timeout=0.
- Reset mid-operation: rst asserted during OWN of requester 3. Required: oe=0, gnt=0000, S=00, busy=0 after the next edge. With req=1111 afterwards, requester 0 is granted first.

Source files
------------

// File: rtl/bus_arbiter_rr_if.sv
// Bus-side signals between the round-robin arbiter, its four requesters and the
// shared 4:1 tri-state multiplexer.
interface bus_arbiter_rr_if;
    localparam int unsigned N_REQ = 4;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] gnt;
    logic [1:0]       S;
    logic             oe;
    logic             busy;
    logic             timeout;

    modport master (
        input  req,
        input  done,
        output gnt,
        output S,
        output oe,
        output busy,
        output timeout
    );

    modport slave (
        output req,
        output done,
        input  gnt,
        input  S,
        input  oe,
        input  busy,
        input  timeout
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin owner selection for a shared 4:1 tri-state bus, with a mandatory
// undriven turnaround between owners and an optional hold limit per grant.
module bus_arbiter_rr #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    bus_arbiter_rr_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, OWN, TURN} state_e;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_e            state_q;
    logic [1:0]        owner_q;
    logic [1:0]        last_q;
    logic [HOLD_W-1:0] hold_q;
    logic [3:0]        gnt_q;
    logic [1:0]        s_q;
    logic              oe_q;
    logic              busy_q;
    logic              timeout_q;

    logic [1:0] win_c;
    logic [1:0] idx_c;
    logic       limit_c;
    logic       done_own_c;
    logic       drop_c;

    // Cyclic search from last+1; walking downwards lets the nearest requester win.
    always_comb begin
        win_c = last_q;
        idx_c = '0;
        for (int k = 4; k >= 1; k--) begin
            idx_c = last_q + 2'(k);
            if (bus.req[idx_c]) begin
                win_c = idx_c;
            end
        end
    end

    assign limit_c    = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
    assign done_own_c = bus.done[owner_q];
    assign drop_c     = !bus.req[owner_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 2'd0;
            last_q    <= 2'd3;
            hold_q    <= '0;
            gnt_q     <= 4'b0000;
            s_q       <= 2'd0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        owner_q <= win_c;
                        s_q     <= win_c;
                        gnt_q   <= 4'b0001 << win_c;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    hold_q  <= '0;
                    oe_q    <= 1'b1;
                    state_q <= OWN;
                end
                OWN: begin
                    hold_q <= hold_q + HOLD_W'(1);
                    if (done_own_c || drop_c || limit_c) begin
                        oe_q      <= 1'b0;
                        gnt_q     <= 4'b0000;
                        // A voluntary release in the limit cycle is not a timeout.
                        timeout_q <= limit_c && !done_own_c && !drop_c;
                        state_q   <= TURN;
                    end
                end
                TURN: begin
                    last_q  <= owner_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.S       = s_q;
    assign bus.oe      = oe_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;
endmodule
